// File: rtl/timer0_prescaler.sv
// ----------------------------------------------------------------------------
// timer0_prescaler
//
// Clock-select and prescaler stage for Timer/Counter0. It produces a
// registered, single-cycle count-enable pulse (tick) that drives the write
// enable of TCNT0. The tick source is selected by CS02:0. It can be the
// system clock, one of four taps of a shared free-running 10-bit prescaler,
// or a synchronised edge on the external T0 pin.
//
// Ports
//   clk     in   1   system clock, all state updates on the rising edge
//   clr     in   1   synchronous active-high reset, highest priority
//   cs      in   3   clock select: 000 stop, 001 clk/1, 010 clk/8,
//                    011 clk/64, 100 clk/256, 101 clk/1024,
//                    110 T0 falling edge, 111 T0 rising edge
//   psr     in   1   prescaler reset strobe (PSR10)
//   t0_pin  in   1   external T0 pin, asynchronous to clk
//   tick    out  1   registered count enable, one clk cycle per event
//   presc   out  10  current prescaler count
// ----------------------------------------------------------------------------
module timer0_prescaler #(
    parameter int PRESC_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic [2:0]             cs,
    input  logic                   psr,
    input  logic                   t0_pin,
    output logic                   tick,
    output logic [PRESC_WIDTH-1:0] presc
);

    localparam logic [PRESC_WIDTH-1:0] PRESC_ONE  = {{(PRESC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PRESC_WIDTH-1:0] PRESC_ZERO = {PRESC_WIDTH{1'b0}};

    logic [PRESC_WIDTH-1:0] presc_q, presc_d;
    logic                   tick_q,  tick_d;
    logic                   s1_q, s2_q, s3_q;
    logic [1:0]             arm_q,   arm_d;

    logic                   armed_s;
    logic                   rise_s;
    logic                   fall_s;

    // Next prescaler count, arm counter and edge-detect terms
    always_comb begin
        presc_d = presc_q;
        arm_d   = arm_q;
        if (psr) begin
            presc_d = PRESC_ZERO;
        end else begin
            presc_d = presc_q + PRESC_ONE;
        end
        // The arm counter saturates at 3 so that the all-zero pipeline
        // left behind by reset cannot be mistaken for a pin edge.
        if (arm_q == 2'd3) begin
            arm_d = 2'd3;
        end else begin
            arm_d = arm_q + 2'd1;
        end
        armed_s = (arm_q == 2'd3);
        rise_s  = armed_s && s2_q && !s3_q;
        fall_s  = armed_s && !s2_q && s3_q;
    end

    // Tick condition for the selected source, evaluated from current state
    always_comb begin
        tick_d = 1'b0;
        case (cs)
            3'b000:  tick_d = 1'b0;
            3'b001:  tick_d = 1'b1;
            3'b010:  tick_d = !psr && (presc_q[2:0] == 3'd7);
            3'b011:  tick_d = !psr && (presc_q[5:0] == 6'd63);
            3'b100:  tick_d = !psr && (presc_q[7:0] == 8'd255);
            3'b101:  tick_d = !psr && (presc_q == {PRESC_WIDTH{1'b1}});
            3'b110:  tick_d = fall_s;
            3'b111:  tick_d = rise_s;
            default: tick_d = 1'b0;
        endcase
    end

    // State registers: prescaler, tick, T0 synchroniser and arm counter
    always_ff @(posedge clk) begin
        if (clr) begin
            presc_q <= PRESC_ZERO;
            tick_q  <= 1'b0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            arm_q   <= 2'd0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            s1_q    <= t0_pin;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            arm_q   <= arm_d;
        end
    end

    assign tick  = tick_q;
    assign presc = presc_q;

endmodule

// File: tb/tb_timer0_prescaler.sv
module tb_timer0_prescaler;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [2:0] cs  = 3'b000;
    logic       psr = 1'b0;
    logic       t0_pin = 1'b0;
    logic       tick;
    logic [9:0] presc;

    int checks = 0;
    int errors = 0;

    timer0_prescaler #(.PRESC_WIDTH(10)) dut (
        .clk    (clk),
        .clr    (clr),
        .cs     (cs),
        .psr    (psr),
        .t0_pin (t0_pin),
        .tick   (tick),
        .presc  (presc)
    );

    always #5 clk = ~clk;

    // Reference model: the prescaler is an integer modulo 1024, and every
    // pin sample since the last reset is kept in a queue.
    int mp = 0;
    bit mtick = 1'b0;
    bit ms[$];

    function automatic bit samp(int i);
        if (i < 0) return 1'b0;
        return ms[i];
    endfunction

    task automatic model_edge(input bit c, input bit p, input bit [2:0] s, input bit t);
        int n;
        int div;
        bit s2;
        bit s3;
        if (c) begin
            mp = 0;
            mtick = 1'b0;
            ms.delete();
        end else begin
            n  = ms.size();
            s2 = samp(n - 2);
            s3 = samp(n - 3);
            div = 0;
            case (s)
                3'd2: div = 8;
                3'd3: div = 64;
                3'd4: div = 256;
                3'd5: div = 1024;
                default: div = 0;
            endcase
            if (s == 3'd0)      mtick = 1'b0;
            else if (s == 3'd1) mtick = 1'b1;
            else if (s == 3'd6) mtick = (n >= 3) && s3 && !s2;
            else if (s == 3'd7) mtick = (n >= 3) && !s3 && s2;
            else                mtick = !p && ((mp % div) == div - 1);
            mp = p ? 0 : (mp + 1) % 1024;
            ms.push_back(t);
        end
    endtask

    task automatic step(input bit c, input bit p, input bit [2:0] s, input bit t);
        clr = c; psr = p; cs = s; t0_pin = t;
        @(posedge clk);
        model_edge(c, p, s, t);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        bit       c;
        bit       p;
        bit [2:0] s;
        bit       t;
        bit       exp_tick;
        int       exp_presc;
    } vec_t;

    vec_t vecs[10];
    int   ticks;
    int   first_at;
    int   hold;
    bit [2:0] rcs;
    bit   rt0;

    initial begin
        // Reset followed by clk/1: the first cycle has no tick, then one every cycle.
        vecs[0] = '{1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 0};
        for (int i = 1; i < 10; i++) vecs[i] = '{1'b0, 1'b0, 3'd1, 1'b0, 1'b1, i};
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].c, vecs[i].p, vecs[i].s, vecs[i].t);
            chk($sformatf("vec%0d_tick", i), int'(tick), int'(vecs[i].exp_tick));
            chk($sformatf("vec%0d_presc", i), int'(presc), vecs[i].exp_presc);
        end

        // clk/8 from reset: ticks only after edges 8,16,24,32,40.
        step(1, 0, 3'd2, 0);
        ticks = 0;
        for (int i = 1; i <= 40; i++) begin
            step(0, 0, 3'd2, 0);
            if (int'(tick) != ((i % 8) == 0 ? 1 : 0))
                chk($sformatf("div8_edge%0d", i), int'(tick), (i % 8) == 0 ? 1 : 0);
            ticks += int'(tick);
        end
        chk("div8_count", ticks, 5);

        // clk/1024 for 2100 edges: ticks after edges 1024 and 2048, and presc wraps.
        step(1, 0, 3'd5, 0);
        ticks = 0;
        for (int i = 1; i <= 2100; i++) begin
            step(0, 0, 3'd5, 0);
            if (tick) begin
                ticks++;
                chk("div1024_pos", i % 1024, 0);
            end
            if (i == 1023) chk("wrap_1023", int'(presc), 1023);
            if (i == 1024) chk("wrap_0", int'(presc), 0);
        end
        chk("div1024_count", ticks, 2);

        // clk/64 with psr at presc=60: no tick at the old boundary, next one 64 edges later.
        step(1, 0, 3'd3, 0);
        for (int i = 1; i <= 60; i++) step(0, 0, 3'd3, 0);
        chk("psr_pre", int'(presc), 60);
        step(0, 1, 3'd3, 0);
        chk("psr_presc", int'(presc), 0);
        ticks = 0; first_at = -1;
        for (int i = 1; i <= 70; i++) begin
            step(0, 0, 3'd3, 0);
            if (tick) begin
                ticks++;
                if (first_at < 0) first_at = i;
            end
        end
        chk("psr_first", first_at, 64);
        chk("psr_count", ticks, 1);

        // Rising mode: the pin idles high through reset, drops, and rises at edge 10.
        step(1, 0, 3'd7, 1);
        ticks = 0; first_at = -1;
        for (int i = 1; i <= 20; i++) begin
            step(0, 0, 3'd7, (i >= 5 && i <= 9) ? 1'b0 : 1'b1);
            if (tick) begin
                ticks++;
                if (first_at < 0) first_at = i;
            end
        end
        chk("rise_first", first_at, 12);
        chk("rise_count", ticks, 1);

        // Falling mode: the pin idles high and falls at edge 10.
        step(1, 0, 3'd6, 1);
        ticks = 0; first_at = -1;
        for (int i = 1; i <= 20; i++) begin
            step(0, 0, 3'd6, (i >= 10) ? 1'b0 : 1'b1);
            if (tick) begin
                ticks++;
                if (first_at < 0) first_at = i;
            end
        end
        chk("fall_first", first_at, 12);
        chk("fall_count", ticks, 1);

        // Stop and resume: no ticks while stopped, presc keeps counting, ticks realign.
        step(1, 0, 3'd2, 0);
        for (int i = 1; i <= 5; i++) step(0, 0, 3'd2, 0);
        ticks = 0;
        for (int i = 6; i <= 25; i++) begin
            step(0, 0, 3'd0, 0);
            ticks += int'(tick);
        end
        chk("stop_ticks", ticks, 0);
        chk("stop_presc", int'(presc), 25);
        first_at = -1;
        for (int i = 26; i <= 40; i++) begin
            step(0, 0, 3'd2, 0);
            if (tick && first_at < 0) first_at = i;
        end
        chk("resume_first", first_at, 32);

        // clr in the middle of a /256 period.
        step(1, 0, 3'd4, 0);
        for (int i = 1; i <= 200; i++) step(0, 0, 3'd4, 0);
        chk("clr_pre", int'(presc), 200);
        step(1, 1, 3'd4, 0);
        chk("clr_tick", int'(tick), 0);
        chk("clr_presc", int'(presc), 0);
        ticks = 0; first_at = -1;
        for (int i = 1; i <= 260; i++) begin
            step(0, 0, 3'd4, 0);
            if (tick) begin
                ticks++;
                if (first_at < 0) first_at = i;
            end
        end
        chk("clr_first", first_at, 256);
        chk("clr_count", ticks, 1);

        // Randomised traffic checked against the model every cycle.
        step(1, 0, 3'd1, 0);
        rcs = 3'd1; rt0 = 1'b0; hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 3) rcs = 3'($urandom_range(0, 7));
            if (hold == 0) begin
                rt0 = ~rt0;
                hold = $urandom_range(0, 6);
            end else begin
                hold--;
            end
            step(($urandom_range(0, 999) < 3) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0, rcs, rt0);
            if (int'(tick) != int'(mtick))
                chk($sformatf("rand%0d_tick", i), int'(tick), int'(mtick));
            if (int'(presc) != mp)
                chk($sformatf("rand%0d_presc", i), int'(presc), mp);
            checks++;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
